// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin share of one external combinational divider
// between NUM_REQ valid/ready clients; operands registered into div_*, result
// captured after DIV_LATENCY edges and returned on shared rsp_* with one-hot
// rsp_valid. Ports: req_* (clients in), rsp_* (clients out), div_* (divider),
// busy. Option DIV_ARB_ZERO_BYPASS_EN: zero divisors answered without divider.
module divider_arbiter #(
  parameter int WIDTH       = 5,
  parameter int NUM_REQ     = 2,
  parameter int DIV_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_div_by_zero,
  output logic                       rsp_overflow,
  output logic [2*WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  input  logic                       div_error_divide_by_zero,
  input  logic                       div_overflow,
  output logic                       busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      last_q, last_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic               found;
  logic [GW-1:0]      win;
  int                 idx;
  logic [2*WIDTH-1:0] win_dvd;
  logic [WIDTH-1:0]   win_dvs;

  // Search starts one past the last winner so every waiter is served in turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  assign win_dvd = req_dividend[int'(win)*2*WIDTH +: 2*WIDTH];
  assign win_dvs = req_divisor[int'(win)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (found) begin
          dvd_d   = win_dvd;
          dvs_d   = win_dvs;
          last_d  = win;
          cnt_d   = CW'(DIV_LATENCY - 1);
          state_d = S_RUN;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (win_dvs == '0) begin
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_RESP;
          end
`endif
        end
      end
      (state_q == S_RUN): begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          dbz_d   = div_error_divide_by_zero;
          ovf_d   = div_overflow;
          state_d = S_RESP;
        end
      end
      (state_q == S_RESP): begin
        if (rsp_ready[last_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_ready = (reset_n && state_q == S_IDLE && found)
                   ? (NUM_REQ'(1) << win) : '0;
  assign rsp_valid = (state_q == S_RESP)
                   ? (NUM_REQ'(1) << last_q) : '0;

  assign rsp_quotient    = quo_q;
  assign rsp_remainder   = rem_q;
  assign rsp_div_by_zero = dbz_q;
  assign rsp_overflow    = ovf_q;
  assign div_dividend    = dvd_q;
  assign div_divisor     = dvs_q;
  assign busy            = (state_q != S_IDLE);

endmodule
